// File: rtl/intercal_alu_issue_if.sv
// Handshake and ALU bundle for the INTERCAL ALU issue/writeback stage.
// master: the environment (instruction source, result sink, ALU).
// slave:  the issue stage itself.
interface intercal_alu_issue_if #(
  parameter int REG_AW = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_op;
  logic [REG_AW-1:0] in_dst;
  logic [REG_AW-1:0] in_src_a;
  logic [REG_AW-1:0] in_src_b;
  logic              in_imm_en;
  logic [31:0]       in_imm;

  logic [3:0]        alu_s;
  logic [31:0]       alu_a;
  logic [31:0]       alu_b;
  logic [31:0]       alu_f;

  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_data;
  logic [REG_AW-1:0] out_dst;

  modport master (
    output in_valid, in_op, in_dst, in_src_a, in_src_b, in_imm_en, in_imm,
    output alu_f, out_ready,
    input  in_ready, alu_s, alu_a, alu_b, out_valid, out_data, out_dst
  );

  modport slave (
    input  in_valid, in_op, in_dst, in_src_a, in_src_b, in_imm_en, in_imm,
    input  alu_f, out_ready,
    output in_ready, alu_s, alu_a, alu_b, out_valid, out_data, out_dst
  );
endinterface

// File: rtl/intercal_alu_issue.sv
// Issue/writeback stage around the combinational INTERCAL ALU.
// IDLE accepts an instruction and registers the ALU inputs, EXEC captures the
// ALU result into the register file and the output register, DONE holds the
// result until the consumer takes it.
// Optional feature macro: INTERCAL_ALU_ISSUE_BYPASS_EN -- when defined, DONE
// accepts the next instruction in the same cycle the result retires.
module intercal_alu_issue #(
  parameter int NREGS  = 16,
  parameter int REG_AW = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  intercal_alu_issue_if.slave bus
);

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t              state_q, state_d;
  logic                in_ready;
  logic                accept;

  logic [3:0]          alu_s_q, alu_s_d;
  logic [DATA_W-1:0]   alu_a_q, alu_a_d;
  logic [DATA_W-1:0]   alu_b_q, alu_b_d;
  logic [REG_AW-1:0]   dst_q, dst_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [REG_AW-1:0]   out_dst_q, out_dst_d;
  logic [DATA_W-1:0]   rf_q [NREGS];
  logic [DATA_W-1:0]   rf_d [NREGS];

  logic [DATA_W-1:0]   opnd_a;
  logic [DATA_W-1:0]   opnd_b;

  // Indices at or above NREGS address no storage: reads give 0, writes vanish.
  function automatic logic in_range(input logic [REG_AW-1:0] idx);
    return int'(idx) < NREGS;
  endfunction

  // State and datapath registers; reset wipes everything including the file.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      alu_s_q     <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      dst_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_dst_q   <= '0;
      for (int i = 0; i < NREGS; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      alu_s_q     <= alu_s_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      dst_q       <= dst_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_dst_q   <= out_dst_d;
      rf_q        <= rf_d;
    end
  end

  // Next-state: accept in IDLE (or DONE with bypass), EXEC always lasts one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = EXEC;
      EXEC: state_d = DONE;
      DONE: if (bus.out_ready) state_d = accept ? EXEC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM output: upstream ready, forced low while reset is asserted.
  always_comb begin
    in_ready = 1'b0;
    if (rst_n) begin
      case (state_q)
        IDLE: in_ready = 1'b1;
        DONE: begin
`ifdef INTERCAL_ALU_ISSUE_BYPASS_EN
          in_ready = bus.out_ready;
`else
          in_ready = 1'b0;
`endif
        end
        default: in_ready = 1'b0;
      endcase
    end
  end

  assign accept = bus.in_valid && in_ready;

  // Operand fetch from the register file; writeback has always landed by now.
  always_comb begin
    opnd_a = in_range(bus.in_src_a) ? rf_q[bus.in_src_a] : '0;
    if (bus.in_imm_en) begin
      opnd_b = bus.in_imm;
    end else begin
      opnd_b = in_range(bus.in_src_b) ? rf_q[bus.in_src_b] : '0;
    end
  end

  // Datapath next values: writeback in EXEC, retire in DONE, capture on accept.
  always_comb begin
    alu_s_d     = alu_s_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    dst_d       = dst_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_dst_d   = out_dst_q;
    rf_d        = rf_q;

    if (state_q == EXEC) begin
      out_valid_d = 1'b1;
      out_data_d  = bus.alu_f;
      out_dst_d   = dst_q;
      if (in_range(dst_q)) begin
        rf_d[dst_q] = bus.alu_f;
      end
    end else if (state_q == DONE && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      alu_s_d = bus.in_op;
      alu_a_d = opnd_a;
      alu_b_d = opnd_b;
      dst_d   = bus.in_dst;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.alu_s     = alu_s_q;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_dst   = out_dst_q;

endmodule

// File: tb/tb_intercal_alu_issue.sv
// Directed scoreboard bench for intercal_alu_issue. The bench supplies the
// combinational ALU and keeps a reference register file; the expected result
// of each instruction is queued at issue time and checked when it appears.
// Built with NREGS=12 so that register indices 12..15 are out of range.
module tb_intercal_alu_issue;

  localparam int NREGS  = 12;
  localparam int REG_AW = 4;
`ifdef INTERCAL_ALU_ISSUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic [31:0]       data;
    logic [REG_AW-1:0] dst;
  } res_t;

  logic clk;
  logic rst_n;

  intercal_alu_issue_if #(.REG_AW(REG_AW)) bus ();

  intercal_alu_issue #(.NREGS(NREGS), .REG_AW(REG_AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  res_t        sb [$];
  logic [31:0] ref_rf [16];
  logic [3:0]  exp_s;
  logic [31:0] exp_a;
  logic [31:0] exp_b;
  logic [31:0] last_data;
  logic [3:0]  last_dst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rotr1(input logic [31:0] x);
    return {x[0], x[31:1]};
  endfunction

  function automatic logic [31:0] select32(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    int k;
    r = '0;
    k = 0;
    for (int i = 0; i < 32; i++) begin
      if (b[i]) begin
        r[k] = a[i];
        k++;
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] mingle(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] r;
    for (int i = 0; i < 16; i++) begin
      r[2*i+1] = a[i];
      r[2*i]   = b[i];
    end
    return r;
  endfunction

  // Stand-in ALU: the ops exercised here follow INTERCAL semantics.
  function automatic logic [31:0] alu_model(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
    case (s)
      4'd0:    return a;
      4'd1:    return b;
      4'd4:    return a & rotr1(a);
      4'd7:    return a | rotr1(a);
      4'd10:   return a ^ rotr1(a);
      4'd13:   return select32(a, b);
      4'd14:   return mingle(a[15:0], b[15:0]);
      default: return a ^ b;
    endcase
  endfunction

  assign bus.alu_f = alu_model(bus.alu_s, bus.alu_a, bus.alu_b);

  function automatic logic [31:0] rd(input logic [3:0] idx);
    return (int'(idx) < NREGS) ? ref_rf[idx] : 32'd0;
  endfunction

  task automatic clear_ref();
    for (int i = 0; i < 16; i++) ref_rf[i] = '0;
    sb.delete();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic expect_push(input logic [3:0] op, input logic [3:0] dst, input logic [3:0] sa,
                             input logic [3:0] sbr, input logic ie, input logic [31:0] imm);
    res_t r;
    exp_s  = op;
    exp_a  = rd(sa);
    exp_b  = ie ? imm : rd(sbr);
    r.data = alu_model(op, exp_a, exp_b);
    r.dst  = dst;
    sb.push_back(r);
    if (int'(dst) < NREGS) ref_rf[dst] = r.data;
  endtask

  // Presents an instruction, waits (bounded) for acceptance; returns in EXEC.
  task automatic issue(input string tag, input logic [3:0] op, input logic [3:0] dst,
                       input logic [3:0] sa, input logic [3:0] sbr, input logic ie,
                       input logic [31:0] imm);
    bit ok;
    bus.in_valid  = 1'b1;
    bus.in_op     = op;
    bus.in_dst    = dst;
    bus.in_src_a  = sa;
    bus.in_src_b  = sbr;
    bus.in_imm_en = ie;
    bus.in_imm    = imm;
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk({tag, "_accept"}, 32'(ok), 32'd1);
    expect_push(op, dst, sa, sbr, ie, imm);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic check_result(input string tag);
    res_t r;
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_pending"}, 32'(sb.size()), 32'd1);
    if (sb.size() > 0) begin
      r = sb.pop_front();
      chk({tag, "_data"}, bus.out_data, r.data);
      chk({tag, "_dst"}, 32'(bus.out_dst), 32'(r.dst));
    end
    last_data = bus.out_data;
    last_dst  = bus.out_dst;
  endtask

  // Full instruction: accept, EXEC, DONE (optionally held for 'hold' cycles), retire.
  task automatic run(input string tag, input logic [3:0] op, input logic [3:0] dst,
                     input logic [3:0] sa, input logic [3:0] sbr, input logic ie,
                     input logic [31:0] imm, input int hold);
    issue(tag, op, dst, sa, sbr, ie, imm);
    chk({tag, "_exec_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_exec_ready"}, 32'(bus.in_ready), 32'd0);
    chk({tag, "_alu_s"}, 32'(bus.alu_s), 32'(exp_s));
    chk({tag, "_alu_a"}, bus.alu_a, exp_a);
    chk({tag, "_alu_b"}, bus.alu_b, exp_b);
    bus.out_ready = (hold == 0);
    @(negedge clk);
    check_result(tag);
    chk({tag, "_done_ready"}, 32'(bus.in_ready), 32'(BYP && (hold == 0)));
    if (hold > 0) begin
      bus.in_valid  = 1'b1;
      bus.in_op     = ~op;
      bus.in_imm_en = 1'b1;
      bus.in_imm    = ~imm;
      bus.in_dst    = dst + 4'd1;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        chk({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_hold_data"}, bus.out_data, last_data);
        chk({tag, "_hold_dst"}, 32'(bus.out_dst), 32'(last_dst));
        chk({tag, "_hold_ready"}, 32'(bus.in_ready), 32'd0);
        chk({tag, "_hold_alu_b"}, bus.alu_b, exp_b);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_retired"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_idle_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_op     = '0;
    bus.in_dst    = '0;
    bus.in_src_a  = '0;
    bus.in_src_b  = '0;
    bus.in_imm_en = 1'b0;
    bus.in_imm    = '0;
    bus.out_ready = 1'b1;
    clear_ref();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_alu_s", 32'(bus.alu_s), 32'd0);
    chk("rst_alu_a", bus.alu_a, 32'd0);
    chk("rst_alu_b", bus.alu_b, 32'd0);
    chk("rst_out_data", bus.out_data, 32'd0);
    chk("rst_out_dst", 32'(bus.out_dst), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(bus.in_ready), 32'd1);

    run("ldi", 4'd1, 4'd3, 4'd0, 4'd0, 1'b1, 32'h0000_1234, 0);
    chk("ldi_lit", last_data, 32'h0000_1234);
    run("mov", 4'd0, 4'd6, 4'd3, 4'd0, 1'b0, 32'h0, 0);
    chk("mov_lit", last_data, 32'h0000_1234);
    run("ld_r1", 4'd1, 4'd1, 4'd0, 4'd0, 1'b1, 32'h0000_FFFF, 0);
    run("ld_r2", 4'd1, 4'd2, 4'd0, 4'd0, 1'b1, 32'h0000_0000, 0);
    run("mingle", 4'd14, 4'd7, 4'd1, 4'd2, 1'b0, 32'h0, 0);
    chk("mingle_lit", last_data, 32'hAAAA_AAAA);
    run("ld_r1b", 4'd1, 4'd1, 4'd0, 4'd0, 1'b1, 32'h1234_5678, 0);
    run("select", 4'd13, 4'd8, 4'd1, 4'd0, 1'b1, 32'h0000_FFFF, 0);
    chk("select_lit", last_data, 32'h0000_5678);
    run("ld_r4", 4'd1, 4'd4, 4'd0, 4'd0, 1'b1, 32'h0000_0003, 0);
    run("and32", 4'd4, 4'd4, 4'd4, 4'd0, 1'b0, 32'h0, 0);
    chk("and32_lit", last_data, 32'h0000_0001);
    run("rd_r4", 4'd0, 4'd9, 4'd4, 4'd0, 1'b0, 32'h0, 0);
    chk("rd_r4_lit", last_data, 32'h0000_0001);
    run("alias", 4'd14, 4'd4, 4'd4, 4'd4, 1'b0, 32'h0, 0);
    run("oor_wr", 4'd1, 4'd13, 4'd0, 4'd0, 1'b1, 32'hCAFE_F00D, 0);
    run("oor_rda", 4'd0, 4'd10, 4'd13, 4'd0, 1'b0, 32'h0, 0);
    run("oor_rdb", 4'd1, 4'd11, 4'd0, 4'd14, 1'b0, 32'h0, 0);
    run("bp", 4'd1, 4'd9, 4'd0, 4'd0, 1'b1, 32'h0000_55AA, 5);

    // Reset during EXEC: instruction lost, register file cleared.
    issue("rst_exec", 4'd1, 4'd5, 4'd0, 4'd0, 1'b1, 32'hDEAD_BEEF);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_exec_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_exec_ready", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b1;
    clear_ref();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_exec_quiet", 32'(bus.out_valid), 32'd0);
    end
    run("r5_clr", 4'd0, 4'd0, 4'd5, 4'd0, 1'b0, 32'h0, 0);
    chk("r5_clr_lit", last_data, 32'h0);
    run("ld_r3", 4'd1, 4'd3, 4'd0, 4'd0, 1'b1, 32'h0000_0042, 0);

    // Reset during DONE: result discarded, r3 cleared again.
    issue("rst_done", 4'd1, 4'd2, 4'd0, 4'd0, 1'b1, 32'h0000_0077);
    bus.out_ready = 1'b0;
    @(negedge clk);
    check_result("rst_done");
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_done_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_done_data", bus.out_data, 32'd0);
    chk("rst_done_dst", 32'(bus.out_dst), 32'd0);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    clear_ref();
    @(negedge clk);
    run("r3_clr", 4'd0, 4'd1, 4'd3, 4'd0, 1'b0, 32'h0, 0);
    chk("r3_clr_lit", last_data, 32'h0);

`ifdef INTERCAL_ALU_ISSUE_BYPASS_EN
    // Back-to-back: the second instruction is accepted as the first retires.
    bus.out_ready = 1'b1;
    issue("byp0", 4'd1, 4'd6, 4'd0, 4'd0, 1'b1, 32'h0BAD_CAFE);
    bus.in_valid  = 1'b1;
    bus.in_op     = 4'd0;
    bus.in_dst    = 4'd7;
    bus.in_src_a  = 4'd6;
    bus.in_src_b  = 4'd0;
    bus.in_imm_en = 1'b0;
    @(negedge clk);
    chk("byp0_done_ready", 32'(bus.in_ready), 32'd1);
    check_result("byp0");
    expect_push(4'd0, 4'd7, 4'd6, 4'd0, 1'b0, 32'h0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("byp1_exec_valid", 32'(bus.out_valid), 32'd0);
    chk("byp1_alu_a", bus.alu_a, exp_a);
    @(negedge clk);
    check_result("byp1");
    chk("byp1_lit", last_data, 32'h0BAD_CAFE);
    @(negedge clk);
    chk("byp1_retired", 32'(bus.out_valid), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
